// File: rtl/bf_pkg.sv
// Shared constants, state encoding and row-count helper for the Bellman-Ford pass scheduler.
package bf_pkg;

  localparam int DIST_W = 16;
  localparam int LANES  = 8;
  localparam logic [DIST_W-1:0] INF = {DIST_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CHECK = 3'd4,
    ST_COPY  = 3'd5,
    ST_DONE  = 3'd6
  } bf_sched_state_t;

  function automatic logic [8:0] ceil_rows(input logic [7:0] n);
    ceil_rows = ({1'b0, n} + 9'(LANES - 1)) / 9'(LANES);
  endfunction

endpackage

// File: rtl/bf_outst_ctr.sv
// Saturating count of edge rows in flight in the relax datapath.
module bf_outst_ctr #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  logic [CNT_W-1:0] r_count;

  // A simultaneous issue and retire leaves the count alone; a retire at zero is spurious.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_inc && !i_dec && r_count != CNT_W'(MAX_OUTST)) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_dec && !i_inc && r_count != {CNT_W{1'b0}}) begin
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_full  = (r_count == CNT_W'(MAX_OUTST));
  assign o_empty = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/bf_pass_scheduler.sv
// Bellman-Ford top-level sequencer: initialise WM, run relaxation passes until a pass is
// quiescent (or N passes flag a negative cycle), then copy WM rows into output memory.
module bf_pass_scheduler
  import bf_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 128,
  parameter int MAX_OUTST = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_node_count,
  input  logic [7:0]        i_src_node,
  input  logic [ADDR_W-1:0] i_edge_rows,
  output logic              o_edge_valid,
  output logic [ADDR_W-1:0] o_edge_addr,
  input  logic              i_edge_ready,
  input  logic              i_relax_ack,
  input  logic              i_relax_update,
  output logic              o_wm_own,
  output logic              o_wm_we,
  output logic [ADDR_W-1:0] o_wm_waddr,
  output logic [DATA_W-1:0] o_wm_wdata,
  output logic [ADDR_W-1:0] o_wm_raddr,
  input  logic [DATA_W-1:0] i_wm_rdata,
  output logic              o_om_we,
  output logic [ADDR_W-1:0] o_om_waddr,
  output logic [DATA_W-1:0] o_om_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_pass_count,
  output logic              o_neg_cycle
);

  bf_sched_state_t   r_state, w_next;
  logic [ADDR_W-1:0] r_row, r_e, r_rows, w_start_rows, w_src_row;
  logic [7:0]        r_n, r_src, r_pass;
  logic              r_neg, r_dirty, r_busy;
  logic              w_full, w_empty, w_edge_valid, w_hs, w_dirty_now;
  logic [DATA_W-1:0] w_init_row;

  bf_outst_ctr #(.MAX_OUTST(MAX_OUTST)) u_outst (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_hs),
    .i_dec   (i_relax_ack),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_start_rows = ADDR_W'(ceil_rows(i_node_count));
  assign w_src_row    = ADDR_W'(r_src / 8'(LANES));
  assign w_edge_valid = (r_state == ST_ISSUE) && (r_row < r_e) && !w_full;
  assign w_hs         = w_edge_valid && i_edge_ready;
  assign w_dirty_now  = r_dirty | i_relax_update;

  // INIT row: every lane unreachable except the source lane in the source's row.
  always_comb begin
    w_init_row = {DATA_W{1'b1}};
    for (int l = 0; l < LANES; l++) begin
      if (r_row == w_src_row && l == int'(r_src % 8'(LANES))) begin
        w_init_row[l*DIST_W +: DIST_W] = {DIST_W{1'b0}};
      end else begin
        w_init_row[l*DIST_W +: DIST_W] = INF;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!i_start)                                      w_next = ST_IDLE;
        else if (w_start_rows == {ADDR_W{1'b0}})           w_next = ST_DONE;
        else if (i_node_count <= 8'd1 || i_src_node >= i_node_count) w_next = ST_COPY;
        else                                               w_next = ST_INIT;
      end
      ST_INIT:  w_next = (r_row == r_rows - ADDR_W'(1)) ? ST_ISSUE : ST_INIT;
      ST_ISSUE: begin
        if (r_e == {ADDR_W{1'b0}} || (w_hs && r_row == r_e - ADDR_W'(1))) w_next = ST_DRAIN;
        else                                                            w_next = ST_ISSUE;
      end
      ST_DRAIN: w_next = w_empty ? ST_CHECK : ST_DRAIN;
      ST_CHECK: begin
        if (w_dirty_now && r_pass < r_n) w_next = ST_ISSUE;
        else                             w_next = ST_COPY;
      end
      ST_COPY:  w_next = (r_row == r_rows - ADDR_W'(1)) ? ST_DONE : ST_COPY;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // r_row is the per-state row/edge index, restarted on every state change.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_row   <= {ADDR_W{1'b0}};
      r_e     <= {ADDR_W{1'b0}};
      r_rows  <= {ADDR_W{1'b0}};
      r_n     <= 8'd0;
      r_src   <= 8'd0;
      r_pass  <= 8'd0;
      r_neg   <= 1'b0;
      r_dirty <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)                                  r_row <= {ADDR_W{1'b0}};
      else if (r_state == ST_INIT || r_state == ST_COPY || w_hs) r_row <= r_row + ADDR_W'(1);
      else                                                    r_row <= r_row;
      if (r_state == ST_IDLE && i_start) begin
        r_n    <= i_node_count;
        r_src  <= i_src_node;
        r_e    <= i_edge_rows;
        r_rows <= w_start_rows;
        r_pass <= 8'd0;
        r_neg  <= 1'b0;
        r_busy <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_busy <= 1'b0;
      end
      if (w_next == ST_ISSUE && r_state != ST_ISSUE) begin
        r_pass  <= r_pass + 8'd1;
        r_dirty <= 1'b0;
      end else if (r_state == ST_ISSUE || r_state == ST_DRAIN || r_state == ST_CHECK) begin
        r_dirty <= w_dirty_now;
      end
      if (r_state == ST_CHECK && w_dirty_now && r_pass == r_n) r_neg <= 1'b1;
    end
  end

  // Memory-side outputs decode directly from the registered state and row index.
  always_comb begin
    o_wm_own   = 1'b0;
    o_wm_we    = 1'b0;
    o_wm_waddr = {ADDR_W{1'b0}};
    o_wm_wdata = {DATA_W{1'b0}};
    o_wm_raddr = {ADDR_W{1'b0}};
    o_om_we    = 1'b0;
    o_om_waddr = {ADDR_W{1'b0}};
    o_om_wdata = {DATA_W{1'b0}};
    if (r_state == ST_INIT) begin
      o_wm_own   = 1'b1;
      o_wm_we    = 1'b1;
      o_wm_waddr = r_row;
      o_wm_wdata = w_init_row;
    end else if (r_state == ST_COPY) begin
      o_wm_raddr = r_row;
      o_om_we    = 1'b1;
      o_om_waddr = r_row;
      o_om_wdata = i_wm_rdata;
    end else begin
      o_wm_own   = 1'b0;
      o_om_we    = 1'b0;
    end
  end

  assign o_edge_valid = w_edge_valid;
  assign o_edge_addr  = (r_state == ST_ISSUE) ? r_row : {ADDR_W{1'b0}};
  assign o_busy       = r_busy;
  assign o_done       = (r_state == ST_DONE);
  assign o_pass_count = r_pass;
  assign o_neg_cycle  = r_neg;

endmodule

// File: tb/tb_bf_pass_scheduler.sv
// Randomised bench for bf_pass_scheduler: a behavioural relax datapath plus a pass/row model.
module tb_bf_pass_scheduler;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 128;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset, start, edge_valid, edge_ready, relax_ack, relax_update;
  logic [7:0]        node_count, src_node, pass_count;
  logic [ADDR_W-1:0] edge_rows, edge_addr, wm_waddr, wm_raddr, om_waddr;
  logic              wm_own, wm_we, om_we, busy, done, neg_cycle;
  logic [DATA_W-1:0] wm_wdata, wm_rdata, om_wdata;
  logic [DATA_W-1:0] wm_mem [0:63];
  logic [DATA_W-1:0] preload [0:63];

  assign wm_rdata = wm_mem[wm_raddr[5:0]];

  bf_pass_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(4)) dut (
    .i_clock(clock), .i_reset(reset), .i_start(start),
    .i_node_count(node_count), .i_src_node(src_node), .i_edge_rows(edge_rows),
    .o_edge_valid(edge_valid), .o_edge_addr(edge_addr), .i_edge_ready(edge_ready),
    .i_relax_ack(relax_ack), .i_relax_update(relax_update),
    .o_wm_own(wm_own), .o_wm_we(wm_we), .o_wm_waddr(wm_waddr), .o_wm_wdata(wm_wdata),
    .o_wm_raddr(wm_raddr), .i_wm_rdata(wm_rdata),
    .o_om_we(om_we), .o_om_waddr(om_waddr), .o_om_wdata(om_wdata),
    .o_busy(busy), .o_done(done), .o_pass_count(pass_count), .o_neg_cycle(neg_cycle)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, run_start = 0;
  int inflight = 0, hs_count = 0, wm_wr_count = 0, om_wr_count = 0, done_count = 0;
  int ack_due[$];
  int ack_pass[$];
  int cfg_n = 0, cfg_src = 0, cfg_e = 1, cfg_delay = 1, cfg_stall = 0;
  bit cfg_rnd = 1'b0, cfg_init = 1'b0;
  logic [63:0] cfg_mask = 64'd0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] init_row(input int src, input int r);
    logic [DATA_W-1:0] v;
    v = {DATA_W{1'b1}};
    if (r == src / 8) v[(src % 8) * 16 +: 16] = 16'h0000;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] exp_row(input int r);
    if (cfg_init) return init_row(cfg_src, r);
    return preload[r % 64];
  endfunction

  // One clock: drive datapath inputs at the falling edge, then observe and score the DUT.
  task automatic step();
    logic ack_now;
    @(negedge clock);
    cyc++;
    ack_now = (ack_due.size() > 0) && (ack_due[0] <= cyc);
    relax_ack    = ack_now;
    relax_update = ack_now ? cfg_mask[ack_pass[0]] : 1'b0;
    if ((cyc - run_start) < cfg_stall) edge_ready = 1'b0;
    else if (cfg_rnd)                  edge_ready = ($urandom_range(0, 1) == 1);
    else                               edge_ready = 1'b1;
    #1;
    if (cfg_e == 0) begin
      check_eq("e0_no_edge", DATA_W'(edge_valid), DATA_W'(0));
    end else if (edge_valid) begin
      check_eq("outst_below_max", DATA_W'(inflight < 4), DATA_W'(1));
      if (edge_ready) begin
        check_eq("edge_addr", DATA_W'(edge_addr), DATA_W'(hs_count % cfg_e));
        ack_due.push_back(cyc + cfg_delay);
        ack_pass.push_back(hs_count / cfg_e + 1);
        hs_count++;
        inflight++;
      end
    end
    if (ack_now) begin
      void'(ack_due.pop_front());
      void'(ack_pass.pop_front());
      inflight--;
    end
    if (wm_we) begin
      check_eq("wm_own", DATA_W'(wm_own), DATA_W'(1));
      check_eq("wm_waddr", DATA_W'(wm_waddr), DATA_W'(wm_wr_count));
      check_eq("wm_wdata", wm_wdata, init_row(cfg_src, wm_wr_count));
      wm_mem[wm_waddr[5:0]] = wm_wdata;
      wm_wr_count++;
    end
    if (om_we) begin
      check_eq("copy_after_drain", DATA_W'(inflight), DATA_W'(0));
      check_eq("om_waddr", DATA_W'(om_waddr), DATA_W'(om_wr_count));
      check_eq("om_wdata", om_wdata, exp_row(om_wr_count));
      om_wr_count++;
    end
    if (done) done_count++;
  endtask

  task automatic setup(input int n, input int src, input int e, input logic [63:0] mask,
                       input int delay, input int stall, input bit rnd);
    cfg_n = n; cfg_src = src; cfg_e = e; cfg_mask = mask;
    cfg_delay = delay; cfg_stall = stall; cfg_rnd = rnd;
    cfg_init = (n > 1) && (src < n);
    for (int i = 0; i < 64; i++) begin
      preload[i] = {$urandom, $urandom, $urandom, $urandom};
      wm_mem[i]  = preload[i];
    end
    ack_due.delete(); ack_pass.delete();
    inflight = 0; hs_count = 0; wm_wr_count = 0; om_wr_count = 0; done_count = 0;
    node_count = 8'(n); src_node = 8'(src); edge_rows = ADDR_W'(e);
    start = 1'b1;
    run_start = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic run_case(input string name, input int n, input int src, input int e,
                          input logic [63:0] mask, input int delay, input int stall,
                          input bit rnd, input bit poke);
    int exp_pass, budget, iter, rows;
    bit exp_neg;
    setup(n, src, e, mask, delay, stall, rnd);
    rows = (n + 7) / 8;
    exp_pass = 0;
    exp_neg  = 1'b0;
    if (cfg_init) begin
      for (int p = 1; p <= n; p++) begin
        exp_pass = p;
        if (!(e > 0 && mask[p])) break;
        if (p == n) exp_neg = 1'b1;
      end
    end
    budget = 20000;
    iter = 0;
    while (done_count == 0 && budget > 0) begin
      if (poke && iter == 4) begin
        start = 1'b1; node_count = 8'd37; src_node = 8'd0; edge_rows = ADDR_W'(2);
      end else begin
        start = 1'b0;
      end
      step();
      iter++;
      budget--;
    end
    start = 1'b0;
    check_eq({name, "_done_seen"}, DATA_W'(done_count), DATA_W'(1));
    check_eq({name, "_busy_at_done"}, DATA_W'(busy), DATA_W'(1));
    check_eq({name, "_pass_count"}, DATA_W'(pass_count), DATA_W'(exp_pass));
    check_eq({name, "_neg_cycle"}, DATA_W'(neg_cycle), DATA_W'(exp_neg));
    check_eq({name, "_edges"}, DATA_W'(hs_count), DATA_W'(e * exp_pass));
    check_eq({name, "_wm_rows"}, DATA_W'(wm_wr_count), DATA_W'(cfg_init ? rows : 0));
    check_eq({name, "_om_rows"}, DATA_W'(om_wr_count), DATA_W'(rows));
    check_eq({name, "_drained"}, DATA_W'(inflight), DATA_W'(0));
    step();
    check_eq({name, "_busy_after"}, DATA_W'(busy), DATA_W'(0));
    step();
    check_eq({name, "_done_once"}, DATA_W'(done_count), DATA_W'(1));
    check_eq({name, "_neg_held"}, DATA_W'(neg_cycle), DATA_W'(exp_neg));
  endtask

  task automatic abort_case();
    int budget;
    setup(8, 2, 8, {64{1'b1}}, 10, 0, 1'b0);
    budget = 200;
    while (!edge_valid && budget > 0) begin
      step();
      budget--;
    end
    check_eq("abort_in_issue", DATA_W'(edge_valid), DATA_W'(1));
    reset = 1'b1;
    step();
    check_eq("abort_ctrl", DATA_W'({edge_valid, wm_own, wm_we, om_we, busy, done, neg_cycle}), DATA_W'(0));
    check_eq("abort_pass", DATA_W'(pass_count), DATA_W'(0));
    check_eq("abort_addr", DATA_W'({edge_addr, wm_waddr, wm_raddr, om_waddr}), DATA_W'(0));
    reset = 1'b0;
    ack_due.delete(); ack_pass.delete();
    inflight = 0; done_count = 0;
    repeat (5) step();
    check_eq("abort_no_done", DATA_W'(done_count), DATA_W'(0));
    check_eq("abort_idle", DATA_W'(busy), DATA_W'(0));
  endtask

  initial begin
    int rn, rs;
    reset = 1'b1; start = 1'b0; node_count = 8'd0; src_node = 8'd0; edge_rows = '0;
    edge_ready = 1'b0; relax_ack = 1'b0; relax_update = 1'b0;
    for (int i = 0; i < 64; i++) wm_mem[i] = '0;
    repeat (3) step();
    check_eq("rst_ctrl", DATA_W'({edge_valid, wm_own, wm_we, om_we, busy, done, neg_cycle}), DATA_W'(0));
    check_eq("rst_pass", DATA_W'(pass_count), DATA_W'(0));
    check_eq("rst_addr", DATA_W'({edge_addr, wm_waddr, wm_raddr, om_waddr}), DATA_W'(0));
    check_eq("rst_data", wm_wdata | om_wdata, DATA_W'(0));
    reset = 1'b0;
    step();

    run_case("basic",    8,  3, 4,  64'd0,                 1,  0, 1'b0, 1'b0);
    run_case("three",    20, 9, 6,  64'h6,                 1,  0, 1'b0, 1'b1);
    run_case("negcyc",   4,  0, 3,  {64{1'b1}},            1,  0, 1'b0, 1'b0);
    run_case("stall",    16, 5, 12, 64'h2,                 10, 8, 1'b1, 1'b0);
    run_case("e_zero",   6,  1, 0,  {64{1'b1}},            1,  0, 1'b0, 1'b0);
    run_case("n_one",    1,  0, 5,  {64{1'b1}},            1,  0, 1'b0, 1'b0);
    run_case("n_zero",   0,  0, 5,  {64{1'b1}},            1,  0, 1'b0, 1'b0);
    run_case("bad_src",  5,  7, 3,  {64{1'b1}},            1,  0, 1'b0, 1'b0);
    abort_case();
    run_case("post_rst", 12, 11, 5, 64'h2,                 2,  0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      rn = $urandom_range(0, 40);
      rs = $urandom_range(0, rn + 2);
      run_case("rand", rn, rs, $urandom_range(0, 12), {$urandom, $urandom},
               $urandom_range(1, 6), $urandom_range(0, 4), 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
